ram_bank: RTL and testbench



---
 rtl/ram_bank_pkg.sv | 17 +
 rtl/ram_bank_core.sv | 44 ++++
 rtl/ram_bank.sv | 114 +++++++++++
 tb/tb_ram_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared types and defaults for the ram_bank storage block.
// Holds the bank FSM state encoding, default geometry and byte-lane helper.
package ram_bank_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int DW_DEFAULT = 8;
   localparam int AW_DEFAULT = 10;

   function automatic int calc_nbe(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/ram_bank_core.sv
// Storage array: byte-enabled write, synchronous registered read (1 cycle), no backpressure.
// Array contents are never reset; only the read data register is.
module ram_bank_core
   import ram_bank_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int AW  = AW_DEFAULT,
   parameter int NBE = calc_nbe(DW)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           we_i,
   input  logic           re_i,
   input  logic [AW-1:0]  addr_i,
   input  logic [DW-1:0]  wdata_i,
   input  logic [NBE-1:0] be_i,
   output logic [DW-1:0]  rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < NBE; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Read register only loads on a read so the response data holds between reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM bank with clear sequencer; read latency 1 (2 with RAM_BANK_OUTREG_EN).
// req_ready is low while clearing; responses cannot be back-pressured.
module ram_bank
   import ram_bank_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int AW  = AW_DEFAULT,
   parameter int NBE = calc_nbe(DW)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_we,
   input  logic [AW-1:0]  req_addr,
   input  logic [DW-1:0]  req_wdata,
   input  logic [NBE-1:0] req_be,
   output logic           rsp_valid,
   output logic [DW-1:0]  rsp_rdata,
   output logic           init_done
);

   localparam logic [AW-1:0] CNT_LAST = '1;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          rd_vld_q, rd_vld_d;
   logic          clearing, acc;
   logic          core_we, core_re;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic [NBE-1:0] core_be;

   assign clearing  = (state_q == ST_CLEAR);
   assign req_ready = (state_q == ST_READY);
   assign init_done = (state_q == ST_READY);
   assign acc       = req_valid & req_ready;
   assign rd_vld_d  = acc & ~req_we;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == CNT_LAST) state_d = ST_READY;
         end
         ST_READY: begin
            // An accepted request in this cycle still completes; clearing starts next cycle.
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_CLEAR;
         cnt_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign core_we    = clearing | (acc & req_we);
   assign core_re    = rd_vld_d;
   assign core_addr  = clearing ? cnt_q : req_addr;
   assign core_wdata = clearing ? '0 : req_wdata;
   assign core_be    = clearing ? '1 : req_be;

   ram_bank_core #(
      .DW  (DW),
      .AW  (AW),
      .NBE (NBE)
   ) u_core (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (core_we),
      .re_i    (core_re),
      .addr_i  (core_addr),
      .wdata_i (core_wdata),
      .be_i    (core_be),
      .rdata_o (core_rdata)
   );

`ifdef RAM_BANK_OUTREG_EN
   logic          rsp_vld_q;
   logic [DW-1:0] rsp_dat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
      end else begin
         rsp_vld_q <= rd_vld_q;
         if (rd_vld_q) rsp_dat_q <= core_rdata;
      end
   end

   assign rsp_valid = rsp_vld_q;
   assign rsp_rdata = rsp_dat_q;
`else
   assign rsp_valid = rd_vld_q;
   assign rsp_rdata = core_rdata;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Directed + random bench for ram_bank (DW=32, AW=8) against a word-array reference model.
module tb_ram_bank;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int NBE   = DW / 8;
   localparam int DEPTH = 2 ** AW;
`ifdef RAM_BANK_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clr;
   logic           req_valid;
   logic           req_ready;
   logic           req_we;
   logic [AW-1:0]  req_addr;
   logic [DW-1:0]  req_wdata;
   logic [NBE-1:0] req_be;
   logic           rsp_valid;
   logic [DW-1:0]  rsp_rdata;
   logic           init_done;

   ram_bank #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rsp_t;

   logic [DW-1:0] m_mem [DEPTH];
   rsp_t          exp_q [$];
   int            clear_left;
   logic [DW-1:0] last_rdata;
   int            cyc;
   int            checks;
   int            errors;

   function automatic logic m_ready();
      return (clear_left == 0);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic exp_v;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("req_ready", DW'(req_ready), DW'(m_ready()));
      chk("init_done", DW'(init_done), DW'(m_ready()));
      chk("rsp_valid", DW'(rsp_valid), DW'(exp_v));
      if (exp_v) begin
         last_rdata = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      chk("rsp_rdata", rsp_rdata, last_rdata);
   endtask

   task automatic zero_model();
      foreach (m_mem[i]) m_mem[i] = '0;
   endtask

   // Drive one cycle of inputs from a negedge, apply the model at the edge, check after it.
   task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NBE-1:0] be, input logic c);
      logic rdy;
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; clr = c;
      rdy = m_ready();
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         if (rdy) begin
            if (v && we) begin
               for (int b = 0; b < NBE; b++)
                  if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
            end else if (v) begin
               exp_q.push_back('{due: cyc + L - 1, data: m_mem[a]});
            end
            if (c) begin
               clear_left = DEPTH;
               zero_model();
            end
         end else begin
            clear_left--;
         end
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      last_rdata = '0;
      clear_left = DEPTH;
      zero_model();
      #1;
      check_outputs();
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; clr = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      last_rdata = '0;
      clear_left = DEPTH;
      zero_model();
      #1;
      check_outputs();
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;

      // Clear after reset, then every address reads zero.
      idle(DEPTH + 2);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
      idle(L + 1);

      // Write then read next cycle.
      step(1'b1, 1'b1, AW'(200), 32'h82, '1, 1'b0);
      step(1'b1, 1'b0, AW'(200), '0, '0, 1'b0);
      idle(L);

      // Byte-lane merge.
      step(1'b1, 1'b1, AW'(5), 32'hAABBCCDD, 4'b1111, 1'b0);
      step(1'b1, 1'b1, AW'(5), 32'h11223344, 4'b0101, 1'b0);
      step(1'b1, 1'b0, AW'(5), '0, '0, 1'b0);
      idle(L - 1);
      chk("be_merge_vld", DW'(rsp_valid), DW'(1));
      chk("be_merge_dat", rsp_rdata, 32'hAA22CC44);
      idle(2);

      // Streaming reads after writes of i*3.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, AW'(i), DW'(i * 3), '1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
      idle(L + 1);

      // clr alongside a read: pre-clear data delivered, then full clear.
      step(1'b1, 1'b1, AW'(9), 32'h34, '1, 1'b0);
      step(1'b1, 1'b0, AW'(9), '0, '0, 1'b1);
      idle(DEPTH + 2);
      step(1'b1, 1'b0, AW'(9), '0, '0, 1'b0);
      idle(L + 1);

      // Random traffic with occasional clr.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(3) != 0, $urandom_range(1) == 1, AW'($urandom_range(15)),
              DW'($urandom), NBE'($urandom_range(15)), $urandom_range(79) == 0);
      end
      idle(DEPTH + L + 2);

      // Reset shortly after an accepted read flushes the response.
      step(1'b1, 1'b1, AW'(3), 32'hDEADBEEF, '1, 1'b0);
      step(1'b1, 1'b0, AW'(3), '0, '0, 1'b0);
      apply_reset();
      idle(3);
      rst_n = 1'b1;
      idle(DEPTH + 2);
      step(1'b1, 1'b0, AW'(3), '0, '0, 1'b0);
      idle(L + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
